// File: rtl/aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_arbiter
//
// Shares one pipelined AES cipher core between two independent requesters.
// Each requester hands over a plaintext block and its key with a valid/ready
// handshake. A round-robin grant picks at most one requester per cycle. The
// granted block and key are registered onto the core inputs. A LAT-deep tag
// pipeline follows every issue slot, so the core output can be routed back to
// its owner when the matching tag leaves the last stage. Every requester has
// one result slot, held until its result handshake. A requester may have only
// one outstanding job, so a result slot can never be overwritten.
//
// Parameters
//   LAT     core latency in cycles from the grant edge to the edge where the
//           core output is captured into the result slot (>= 1)
//   DATA_W  block / key width (128 for AES)
//
// Ports
//   clk                  system clock, rising edge
//   rst                  synchronous active-high reset
//   req{0,1}_valid  in   requester offers a block
//   req{0,1}_ready  out  grant; the handshake completes on valid && ready
//   req{0,1}_data   in   plaintext block
//   req{0,1}_key    in   cipher key
//   core_datain     out  registered plaintext to the AES core
//   core_key        out  registered key to the AES core
//   core_dataout    in   ciphertext from the AES core
//   res{0,1}_valid  out  ciphertext waiting for requester i
//   res{0,1}_ready  in   requester i accepts the result
//   res{0,1}_data   out  ciphertext for requester i
// -----------------------------------------------------------------------------
module aes_core_arbiter #(
    parameter int LAT    = 10,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req0_key,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [DATA_W-1:0] req1_key,

    output logic [DATA_W-1:0] core_datain,
    output logic [DATA_W-1:0] core_key,
    input  logic [DATA_W-1:0] core_dataout,

    output logic              res0_valid,
    input  logic              res0_ready,
    output logic [DATA_W-1:0] res0_data,

    output logic              res1_valid,
    input  logic              res1_ready,
    output logic [DATA_W-1:0] res1_data
);

    // Round-robin pick between two eligible requesters. last = 1 means that
    // requester 1 received the most recent grant, so requester 0 wins a tie.
    // Bit 0 of the result is the grant for requester 0.
    function automatic logic [1:0] rr_pick(input logic e0, input logic e1,
                                           input logic last);
        logic [1:0] g;
        g = 2'b00;
        if (e0 && e1) begin
            g = last ? 2'b01 : 2'b10;
        end else if (e0) begin
            g = 2'b01;
        end else if (e1) begin
            g = 2'b10;
        end
        return g;
    endfunction

    logic              busy0;
    logic              busy1;
    logic              rr_last;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              issue;
    logic              issue_id;
    logic              res0_hs;
    logic              res1_hs;

    logic [LAT-1:0]    tag_vld;
    logic [LAT-1:0]    tag_id;
    logic              exit_vld;
    logic              exit_id;

    // Grant: combinational from the registered busy/rr state and the valids.
    // rst is folded into eligibility so that no ready is raised during reset.
    always_comb begin
        elig0    = req0_valid && !busy0 && !rst;
        elig1    = req1_valid && !busy1 && !rst;
        {grant1, grant0} = rr_pick(elig0, elig1, rr_last);
        issue    = grant0 | grant1;
        issue_id = grant1;
        res0_hs  = res0_valid && res0_ready;
        res1_hs  = res1_valid && res1_ready;
        exit_vld = tag_vld[LAT-1];
        exit_id  = tag_id[LAT-1];
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Stage 0: issue control. busy covers the job in flight and its pending
    // result. A grant and a result handshake on the same port cannot coincide,
    // because busy already blocks the grant, so a freed slot can be re-issued
    // at the earliest on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy0   <= 1'b0;
            busy1   <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            if (grant0) begin
                busy0 <= 1'b1;
            end else if (res0_hs) begin
                busy0 <= 1'b0;
            end

            if (grant1) begin
                busy1 <= 1'b1;
            end else if (res1_hs) begin
                busy1 <= 1'b0;
            end

            if (grant0) begin
                rr_last <= 1'b0;
            end else if (grant1) begin
                rr_last <= 1'b1;
            end
        end
    end

    // Stage 0: core input registers. They hold their value when nothing is
    // granted, so an idle core sees a stable input.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_datain <= '0;
            core_key    <= '0;
        end else if (grant0) begin
            core_datain <= req0_data;
            core_key    <= req0_key;
        end else if (grant1) begin
            core_datain <= req1_data;
            core_key    <= req1_key;
        end
    end

    // Stages 0..LAT-1: tag pipeline that tracks the owner of every issue slot.
    // An empty slot (v=0) enters on cycles without a grant. A reset clears all
    // tags, so core results that are still in flight are never delivered.
    generate
        if (LAT == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_vld <= '0;
                    tag_id  <= '0;
                end else begin
                    tag_vld <= issue;
                    tag_id  <= issue_id;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_vld <= '0;
                    tag_id  <= '0;
                end else begin
                    tag_vld <= {tag_vld[LAT-2:0], issue};
                    tag_id  <= {tag_id[LAT-2:0], issue_id};
                end
            end
        end
    endgenerate

    // Stage LAT: result slots. When a valid tag leaves the pipeline, the core
    // output belongs to the tag's owner. The slot then holds until the owner
    // accepts it. An exit and a handshake on the same slot cannot coincide,
    // because the owner cannot issue again while its slot is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
        end else begin
            if (exit_vld && !exit_id) begin
                res0_valid <= 1'b1;
            end else if (res0_hs) begin
                res0_valid <= 1'b0;
            end

            if (exit_vld && exit_id) begin
                res1_valid <= 1'b1;
            end else if (res1_hs) begin
                res1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res0_data <= '0;
            res1_data <= '0;
        end else begin
            if (exit_vld && !exit_id) begin
                res0_data <= core_dataout;
            end
            if (exit_vld && exit_id) begin
                res1_data <= core_dataout;
            end
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_core_arbiter
//
// Self-checking bench for aes_core_arbiter with LAT = 10. The AES core is
// stood in for by a register delay of datain ^ key. The arbiter's own input
// register is the first stage of that delay, so the bench adds LAT-1 more
// stages and the ciphertext reaches the result slot LAT cycles after the
// grant. A transaction-level reference model runs alongside every cycle. It
// holds busy flags, a round-robin preference and a queue of in-flight jobs
// with due times, and it predicts readies, result slots and core inputs.
// -----------------------------------------------------------------------------
module tb_aes_core_arbiter;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data, req1_data, req0_key, req1_key;
    logic [127:0] core_datain, core_key, core_dataout;
    logic         res0_valid, res1_valid, res0_ready, res1_ready;
    logic [127:0] res0_data, res1_data;

    always #5 clk = ~clk;

    aes_core_arbiter #(.LAT(LAT), .DATA_W(128)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_key(req1_key),
        .core_datain(core_datain), .core_key(core_key),
        .core_dataout(core_dataout),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data)
    );

    // Core stand-in: LAT-1 register stages after the arbiter's input register.
    logic [127:0] core_pipe [LAT-1];
    always @(posedge clk) begin
        core_pipe[0] <= core_datain ^ core_key;
        for (int s = 1; s < LAT - 1; s++) core_pipe[s] <= core_pipe[s-1];
    end
    assign core_dataout = core_pipe[LAT-2];

    // ---------------- checking infrastructure ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        int           id;
        logic [127:0] d;
    } job_t;

    job_t         jobs[$];
    logic [1:0]   mbusy  = 2'b00;
    logic         mrr    = 1'b1;      // id granted most recently
    logic [1:0]   mres_v = 2'b00;
    logic [127:0] mres_d [2];
    logic [127:0] mcore_d = '0;
    logic [127:0] mcore_k = '0;
    int           cyc    = 0;
    int           m_iss  = 0;
    logic         chk_en = 1'b0;

    // Per-cycle observations, refreshed at every falling edge.
    logic         hs0, hs1, rv0, rv1;
    logic         prev_rst = 1'b1;
    logic [1:0]   prev_v = 2'b00;
    logic [1:0]   prev_r = 2'b00;
    logic [127:0] prev_d [2];

    task automatic model_step();
        logic e0, e1, g0, g1;
        job_t j;
        e0 = req0_valid && !mbusy[0] && !rst;
        e1 = req1_valid && !mbusy[1] && !rst;
        g0 = e0 && (!e1 || mrr == 1'b1);
        g1 = e1 && (!e0 || mrr == 1'b0);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        rv0 = res0_valid;
        rv1 = res1_valid;

        if (chk_en) begin
            chk1("req0_ready", req0_ready, g0);
            chk1("req1_ready", req1_ready, g1);
            chk1("res0_valid", res0_valid, mres_v[0]);
            chk1("res1_valid", res1_valid, mres_v[1]);
            check("res0_data", res0_data, mres_d[0]);
            check("res1_data", res1_data, mres_d[1]);
            check("core_datain", core_datain, mcore_d);
            check("core_key", core_key, mcore_k);
            // A held result must never be overwritten or dropped before its
            // handshake (this also covers a tag exiting into an occupied slot).
            if (!prev_rst && prev_v[0] && !prev_r[0]) begin
                chk1("res0_hold_valid", res0_valid, 1'b1);
                check("res0_hold_data", res0_data, prev_d[0]);
            end
            if (!prev_rst && prev_v[1] && !prev_r[1]) begin
                chk1("res1_hold_valid", res1_valid, 1'b1);
                check("res1_hold_data", res1_data, prev_d[1]);
            end
        end
        prev_rst  = rst;
        prev_v    = {res1_valid, res0_valid};
        prev_r    = {res1_ready, res0_ready};
        prev_d[0] = res0_data;
        prev_d[1] = res1_data;

        // Effect of the coming rising edge.
        if (rst) begin
            mbusy   = 2'b00;
            mrr     = 1'b1;
            mres_v  = 2'b00;
            mres_d[0] = '0;
            mres_d[1] = '0;
            mcore_d = '0;
            mcore_k = '0;
            jobs.delete();
        end else begin
            if (mres_v[0] && res0_ready) begin mres_v[0] = 1'b0; mbusy[0] = 1'b0; end
            if (mres_v[1] && res1_ready) begin mres_v[1] = 1'b0; mbusy[1] = 1'b0; end
            while (jobs.size() > 0 && jobs[0].due == cyc + 1) begin
                j = jobs.pop_front();
                mres_v[j.id] = 1'b1;
                mres_d[j.id] = j.d;
            end
            if (g0) begin
                mbusy[0] = 1'b1; mrr = 1'b0; m_iss++;
                jobs.push_back('{cyc + 1 + LAT, 0, req0_data ^ req0_key});
                mcore_d = req0_data; mcore_k = req0_key;
            end
            if (g1) begin
                mbusy[1] = 1'b1; mrr = 1'b1; m_iss++;
                jobs.push_back('{cyc + 1 + LAT, 1, req1_data ^ req1_key});
                mcore_d = req1_data; mcore_k = req1_key;
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the model samples at
    // the falling edge, where inputs and combinational readies are stable.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int           port;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vt [4];

    initial begin
        int           k, n0, n1, n_iss, lastid, alt_viol, iss0, nres;
        logic [127:0] exp0, cd, ck, da, ka, db, kb;

        vt[0] = '{0, 128'h31323334353637383132333435363738,
                     128'h30313032303330343035303630373038,
                     128'h010303060505070C0107030205010700, LAT};
        vt[1] = '{1, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
                     128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F,
                     128'hF0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0, LAT};
        vt[2] = '{0, 128'h0123456789ABCDEF0123456789ABCDEF,
                     128'h0123456789ABCDEF0123456789ABCDEF,
                     128'h00000000000000000000000000000000, LAT};
        vt[3] = '{1, 128'h00000000000000000000000000000001,
                     128'h80000000000000000000000000000000,
                     128'h80000000000000000000000000000001, LAT};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        res0_ready = 1'b1; res1_ready = 1'b1;
        mres_d[0] = '0; mres_d[1] = '0;
        prev_d[0] = '0; prev_d[1] = '0;

        // Reset state.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cycle();
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_res0_valid", res0_valid, 1'b0);
        chk1("rst_res1_valid", res1_valid, 1'b0);
        check("rst_core_datain", core_datain, 128'd0);
        check("rst_res1_data", res1_data, 128'd0);
        rst = 1'b0;

        // Table: single requests, immediate accept.
        for (int i = 0; i < 4; i++) begin
            if (vt[i].port == 0) begin
                req0_valid = 1'b1; req0_data = vt[i].data; req0_key = vt[i].key;
            end else begin
                req1_valid = 1'b1; req1_data = vt[i].data; req1_key = vt[i].key;
            end
            #1;
            chk1("tbl_ready", vt[i].port == 0 ? req0_ready : req1_ready, 1'b1);
            cycle();
            req0_valid = 1'b0; req1_valid = 1'b0;
            k = 0;
            while (!(vt[i].port == 0 ? res0_valid : res1_valid) && k < 3 * LAT) begin
                cycle();
                k++;
            end
            chki("tbl_latency", k, vt[i].lat);
            check("tbl_res_data", vt[i].port == 0 ? res0_data : res1_data, vt[i].exp);
            chk1("tbl_other_valid", vt[i].port == 0 ? res1_valid : res0_valid, 1'b0);
            cycle();
            cycle();
        end

        // Simultaneous requests right after reset: req0 wins the first tie.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        da = rnd128(); ka = rnd128(); db = rnd128(); kb = rnd128();
        req0_valid = 1'b1; req0_data = da; req0_key = ka;
        req1_valid = 1'b1; req1_data = db; req1_key = kb;
        #1;
        chk1("tie_req0_ready", req0_ready, 1'b1);
        chk1("tie_req1_ready", req1_ready, 1'b0);
        cycle();
        req0_valid = 1'b0;
        #1;
        chk1("tie_req1_next", req1_ready, 1'b1);
        cycle();
        req1_valid = 1'b0;
        for (int i = 0; i < LAT - 2; i++) cycle();
        chk1("tie_res0_early", res0_valid, 1'b0);
        cycle();
        chk1("tie_res0_valid", res0_valid, 1'b1);
        check("tie_res0_data", res0_data, da ^ ka);
        chk1("tie_res1_not_yet", res1_valid, 1'b0);
        cycle();
        chk1("tie_res1_valid", res1_valid, 1'b1);
        check("tie_res1_data", res1_data, db ^ kb);
        for (int i = 0; i < 3; i++) cycle();

        // Result backpressure on port 0 while port 1 keeps being served.
        res0_ready = 1'b0;
        da = rnd128(); ka = rnd128();
        req0_valid = 1'b1; req0_data = da; req0_key = ka;
        cycle();
        req0_data = rnd128(); req0_key = rnd128();
        req1_valid = 1'b1; req1_data = rnd128(); req1_key = rnd128();
        n0 = 0; n1 = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            cycle();
            if (hs0) n0++;
            if (hs1) begin n1++; req1_data = rnd128(); req1_key = rnd128(); end
        end
        chk1("bp_res0_held", res0_valid, 1'b1);
        check("bp_res0_data", res0_data, da ^ ka);
        chki("bp_req0_grants", n0, 0);
        chk1("bp_req1_served", n1 > 0, 1'b1);
        res0_ready = 1'b1;
        #1;
        chk1("bp_no_same_edge_regrant", req0_ready, 1'b0);
        cycle();
        k = 0;
        while (!req0_ready && k < 3) begin cycle(); k++; end
        chk1("bp_regrant", req0_ready, 1'b1);
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) cycle();

        // Continuous traffic: both valid and both results accepted.
        req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd128();
        req1_valid = 1'b1; req1_data = rnd128(); req1_key = rnd128();
        n_iss = 0; lastid = -1; alt_viol = 0; iss0 = m_iss;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (hs0) begin
                n_iss++; if (lastid == 0) alt_viol++; lastid = 0;
                req0_data = rnd128(); req0_key = rnd128();
            end
            if (hs1) begin
                n_iss++; if (lastid == 1) alt_viol++; lastid = 1;
                req1_data = rnd128(); req1_key = rnd128();
            end
        end
        chki("cont_alternation_violations", alt_viol, 0);
        chki("cont_issue_count", n_iss, m_iss - iss0);
        chk1("cont_issue_rate", n_iss >= 2 * (200 / (LAT + 2)), 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) cycle();

        // Reset four cycles after a req1 handshake.
        req1_valid = 1'b1; req1_data = rnd128(); req1_key = rnd128();
        cycle();
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd128();
        #1;
        chk1("midrst_ready_blocked", req0_ready, 1'b0);
        cycle();
        req0_valid = 1'b0;
        chk1("midrst_res1_valid", res1_valid, 1'b0);
        check("midrst_res1_data", res1_data, 128'd0);
        check("midrst_core_datain", core_datain, 128'd0);
        check("midrst_core_key", core_key, 128'd0);
        rst = 1'b0;
        nres = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            cycle();
            if (rv1) nres++;
        end
        chki("midrst_no_stale_res1", nres, 0);
        db = rnd128(); kb = rnd128();
        req1_valid = 1'b1; req1_data = db; req1_key = kb;
        cycle();
        req1_valid = 1'b0;
        k = 0;
        while (!res1_valid && k < 3 * LAT) begin cycle(); k++; end
        chki("postrst_latency", k, LAT);
        check("postrst_res1_data", res1_data, db ^ kb);
        for (int i = 0; i < 3; i++) cycle();

        // Idle: no valids.
        cd = core_datain; ck = core_key; nres = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (rv0 || rv1) nres++;
        end
        check("idle_core_datain", core_datain, cd);
        check("idle_core_key", core_key, ck);
        chki("idle_res_valids", nres, 0);

        // Randomized traffic with backpressure and occasional resets; the
        // reference model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            res0_ready = ($urandom_range(0, 9) < 6);
            res1_ready = ($urandom_range(0, 9) < 6);
            req0_data = rnd128(); req0_key = rnd128();
            req1_data = rnd128(); req1_key = rnd128();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
